pattern_game_ctrl: RTL



---
 rtl/pattern_game_pkg.sv | 26 ++
 rtl/edge_rise.sv | 24 ++
 rtl/pattern_game_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_game_pkg.sv
// Shared state encodings, symbol type and LFSR helper for the pattern-game sequencer.
package pattern_game_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_APPEND   = 4'd1;
  localparam state_t ST_SHOW     = 4'd2;
  localparam state_t ST_GAP      = 4'd3;
  localparam state_t ST_WAIT_IN  = 4'd4;
  localparam state_t ST_PRESS    = 4'd5;
  localparam state_t ST_CHECK    = 4'd6;
  localparam state_t ST_ROUND_OK = 4'd7;
  localparam state_t ST_WIN      = 4'd8;
  localparam state_t ST_LOSE     = 4'd9;

  typedef logic [1:0] symbol_t;

  // Taps 8,6,5,4 (1-based) of the 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registers a synchronous level once more and flags its rising edge for one cycle.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_cur;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_d;
      r_prev <= r_cur;
    end
  end

  assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/pattern_game_ctrl.sv
// Pattern-game sequencer: grows a random 2-bit pattern, plays it back, checks player entries.
// Optional build macro INPUT_TIMEOUT_EN adds a WAIT_IN timeout (parameter TIMEOUT_CYCLES).
module pattern_game_ctrl
  import pattern_game_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [7:0]  SEED        = 8'hA5
`ifdef INPUT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btnIn,
  input  logic [1:0] myIn,
  input  logic       t,
  input  logic       f,
  output logic [1:0] data,
  output logic       buttonOn,
  output logic       showOn,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned IW   = $clog2(MAX_LEN);
  localparam int unsigned LW   = IW + 1;
  localparam int unsigned CMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  state_t        r_state, w_state_d;
  logic [7:0]    r_lfsr;
  symbol_t       r_pat [MAX_LEN];
  logic [IW-1:0] r_idx, w_idx_d;
  logic [LW-1:0] r_level, w_level_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          w_pat_we;
  logic          w_last;
  logic          w_start_rise;
  logic          w_btn_rise;
  symbol_t       w_cur_sym;

  // myIn is wired straight to the compare stage outside this block.
  logic w_unused_myin;
  assign w_unused_myin = ^myIn;

  edge_rise u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (start),
    .o_rise (w_start_rise)
  );

  edge_rise u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (btnIn),
    .o_rise (w_btn_rise)
  );

  assign w_last    = ({1'b0, r_idx} == (r_level - LW'(1)));
  assign w_cur_sym = r_pat[r_idx];

`ifdef INPUT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == ST_WAIT_IN && !w_btn_rise) begin
      r_tmo <= r_tmo + 16'd1;
    end else begin
      r_tmo <= '0;
    end
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_level_d = r_level;
    w_cnt_d   = r_cnt;
    w_pat_we  = 1'b0;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (w_start_rise) begin
          w_level_d = '0;
          w_state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        w_pat_we  = 1'b1;
        w_level_d = r_level + LW'(1);
        w_idx_d   = '0;
        w_cnt_d   = '0;
        w_state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_cnt_d   = '0;
          w_state_d = ST_GAP;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_d = '0;
          if (w_last) begin
            w_idx_d   = '0;
            w_state_d = ST_WAIT_IN;
          end else begin
            w_idx_d   = r_idx + IW'(1);
            w_state_d = ST_SHOW;
          end
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      ST_WAIT_IN: begin
`ifdef INPUT_TIMEOUT_EN
        if (w_btn_rise) begin
          w_state_d = ST_PRESS;
        end else if (r_tmo == TMO_LAST) begin
          w_state_d = ST_LOSE;
        end
`else
        if (w_btn_rise) begin
          w_state_d = ST_PRESS;
        end
`endif
      end
      ST_PRESS: w_state_d = ST_CHECK;
      ST_CHECK: begin
        // Anything but a clean match (including t==f) ends the game.
        if (t && !f) begin
          if (w_last) begin
            w_state_d = ST_ROUND_OK;
          end else begin
            w_idx_d   = r_idx + IW'(1);
            w_state_d = ST_WAIT_IN;
          end
        end else begin
          w_state_d = ST_LOSE;
        end
      end
      ST_ROUND_OK: w_state_d = (r_level == LEN_MAX) ? ST_WIN : ST_APPEND;
      default:     w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= SEED;
      r_idx   <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_lfsr  <= lfsr_step(r_lfsr);
      r_idx   <= w_idx_d;
      r_level <= w_level_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Pattern storage is never reset; only entries below r_level are read.
  always_ff @(posedge clk) begin
    if (w_pat_we) begin
      r_pat[r_level[IW-1:0]] <= r_lfsr[1:0];
    end
  end

  always_comb begin
    data     = '0;
    showOn   = 1'b0;
    buttonOn = 1'b0;
    busy     = 1'b1;
    case (r_state)
      ST_SHOW: begin
        showOn = 1'b1;
        data   = w_cur_sym;
      end
      ST_WAIT_IN, ST_CHECK: data = w_cur_sym;
      ST_PRESS: begin
        data     = w_cur_sym;
        buttonOn = 1'b1;
      end
      ST_IDLE, ST_WIN, ST_LOSE: busy = 1'b0;
      default: ;
    endcase
  end

  assign win   = (r_state == ST_WIN);
  assign lose  = (r_state == ST_LOSE);
  assign level = 4'(r_level);

endmodule
